regfile_wb_scheduler: RTL and testbench

- Owns the single write port of the 32x32 integer register file.
- Arbitrates between two writeback producers: the ALU result path and the load unit.
- Keeps a per-register busy scoreboard. Issue logic uses it to stall on RAW and WAW hazards until the producing write has been committed to the register file.
- Sits between the execute/memory stages and the register file write inputs (reg_write, write_reg, write_data).

---
 rtl/regfile_wb_scheduler_if.sv | 43 ++++
 rtl/regfile_wb_scheduler.sv | 112 +++++++++++
 tb/tb_regfile_wb_scheduler.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_scheduler_if.sv
// Writeback scheduler bus: issue-side hazard check, ALU/load writeback requests,
// register file write port and busy scoreboard.
interface regfile_wb_scheduler_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                     issue_valid;
  logic [ADDR_W-1:0]        issue_rd;
  logic                     issue_has_rd;
  logic [ADDR_W-1:0]        src_reg1;
  logic [ADDR_W-1:0]        src_reg2;
  logic                     issue_ready;
  logic                     hazard;

  logic                     alu_valid;
  logic [ADDR_W-1:0]        alu_rd;
  logic [DATA_W-1:0]        alu_data;
  logic                     alu_ready;

  logic                     mem_valid;
  logic [ADDR_W-1:0]        mem_rd;
  logic [DATA_W-1:0]        mem_data;
  logic                     mem_ready;

  logic                     reg_write;
  logic [ADDR_W-1:0]        write_reg;
  logic [DATA_W-1:0]        write_data;
  logic [(1<<ADDR_W)-1:0]   busy_vec;

  modport master (
    output issue_valid, issue_rd, issue_has_rd, src_reg1, src_reg2,
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  issue_ready, hazard, alu_ready, mem_ready,
    input  reg_write, write_reg, write_data, busy_vec
  );

  modport slave (
    input  issue_valid, issue_rd, issue_has_rd, src_reg1, src_reg2,
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output issue_ready, hazard, alu_ready, mem_ready,
    output reg_write, write_reg, write_data, busy_vec
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Register file write-port owner: arbitrates ALU/load writebacks into a single
// registered write and tracks outstanding destinations in a busy scoreboard.

module regfile_wb_busy_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic clr,
  output logic busy
);
  // A new producer issuing on the same edge as the old one commits stays outstanding.
  always_ff @(posedge clk) begin
    if (!rst_n)   busy <= 1'b0;
    else if (set) busy <= 1'b1;
    else if (clr) busy <= 1'b0;
  end
endmodule

module regfile_wb_scheduler #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIXED_PRIO = 0
) (
  input logic clk,
  input logic rst_n,
  regfile_wb_scheduler_if.slave bus
);
  localparam int NREG  = 1 << ADDR_W;
  localparam int LANES = 2;  // lane 0 = ALU, lane 1 = load

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  wb_req_t [LANES-1:0] req;
  logic    [LANES-1:0] req_vld;
  logic    [LANES-1:0] gnt;
  wb_req_t             win;
  logic                last_mem_q;

  logic                reg_write_q;
  logic [ADDR_W-1:0]   write_reg_q;
  logic [DATA_W-1:0]   write_data_q;
  logic [NREG-1:0]     busy_q;

  logic                hazard;
  logic                issue_fire;
  logic                set_en;

  assign req[0]     = '{rd: bus.alu_rd, data: bus.alu_data};
  assign req[1]     = '{rd: bus.mem_rd, data: bus.mem_data};
  assign req_vld    = {bus.mem_valid, bus.alu_valid};

  // Hazard looks only at committed scoreboard state, never at in-flight grants.
  assign hazard     = bus.issue_valid &
                      (busy_q[bus.src_reg1] | busy_q[bus.src_reg2] |
                       (bus.issue_has_rd & busy_q[bus.issue_rd]));
  assign issue_fire = bus.issue_valid & ~hazard;
  assign set_en     = issue_fire & bus.issue_has_rd & (bus.issue_rd != '0);

  always_comb begin
    gnt = '0;
    unique case (req_vld)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ((FIXED_PRIO != 0) || !last_mem_q) ? 2'b10 : 2'b01;
      default: gnt = '0;
    endcase
    win = gnt[1] ? req[1] : req[0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_mem_q   <= 1'b0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      if (&req_vld) last_mem_q <= gnt[1];
      if (|gnt) begin
        reg_write_q  <= (win.rd != '0);
        write_reg_q  <= win.rd;
        write_data_q <= win.data;
      end else begin
        reg_write_q  <= 1'b0;
      end
    end
  end

  // x0 is hardwired, so it never gets a scoreboard entry.
  assign busy_q[0] = 1'b0;
  for (genvar i = 1; i < NREG; i++) begin : g_busy
    localparam logic [ADDR_W-1:0] IDX = ADDR_W'(i);
    regfile_wb_busy_bit u_bit (
      .clk   (clk),
      .rst_n (rst_n),
      .set   (set_en && (bus.issue_rd == IDX)),
      .clr   (reg_write_q && (write_reg_q == IDX)),
      .busy  (busy_q[i])
    );
  end

  assign bus.issue_ready = issue_fire;
  assign bus.hazard      = hazard;
  assign bus.alu_ready   = gnt[0];
  assign bus.mem_ready   = gnt[1];
  assign bus.reg_write   = reg_write_q;
  assign bus.write_reg   = write_reg_q;
  assign bus.write_data  = write_data_q;
  assign bus.busy_vec    = busy_q;
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench: expected register-file writes queued by stimulus, popped by a monitor.
module tb_regfile_wb_scheduler;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  regfile_wb_scheduler_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_wb_scheduler #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIXED_PRIO(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] data);
    exp_t e;
    e.rd = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic v, input logic [4:0] rd, input logic has,
                       input logic [4:0] s1, input logic [4:0] s2);
    bus.issue_valid = v; bus.issue_rd = rd; bus.issue_has_rd = has;
    bus.src_reg1 = s1; bus.src_reg2 = s2;
  endtask

  // Every register-file write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.reg_write === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got reg %0d data %0h expected no write",
                 bus.write_reg, bus.write_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.write_reg !== e.rd || bus.write_data !== e.data) begin
          errors++;
          $display("FAIL write: got reg %0d data %0h expected reg %0d data %0h",
                   bus.write_reg, bus.write_data, e.rd, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    issue(1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset then idle
    issue(1'b1, 5'd5, 1'b0, 5'd1, 5'd2);
    smp();
    chk("rst_busy", bus.busy_vec, 0);
    chk("rst_reg_write", bus.reg_write, 0);
    chk("rst_issue_ready", bus.issue_ready, 1);
    chk("rst_hazard", bus.hazard, 0);

    // single ALU write
    step(); issue(1'b1, 5'd7, 1'b1, 5'd1, 5'd2);
    smp();  chk("alu_issue_ready", bus.issue_ready, 1);
    step(); issue(1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'hDEADBEEF;
    push(5'd7, 32'hDEADBEEF);
    smp();  chk("alu_busy7", bus.busy_vec, 64'd1 << 7);
            chk("alu_ready", bus.alu_ready, 1);
            chk("alu_mem_ready", bus.mem_ready, 0);
    step(); bus.alu_valid = 1'b0;
    smp();  chk("alu_reg_write", bus.reg_write, 1);
            chk("alu_busy_held", bus.busy_vec, 64'd1 << 7);
    step();
    smp();  chk("alu_busy_clr", bus.busy_vec, 0);
            chk("alu_reg_write_off", bus.reg_write, 0);

    // RAW stall through the commit cycle
    step(); issue(1'b1, 5'd3, 1'b1, 5'd0, 5'd0);
    smp();  chk("raw_issue3", bus.issue_ready, 1);
    step(); issue(1'b1, 5'd8, 1'b0, 5'd1, 5'd3);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h00003333;
    push(5'd3, 32'h00003333);
    smp();  chk("raw_hazard0", bus.hazard, 1);
            chk("raw_ready0", bus.issue_ready, 0);
            chk("raw_busy3", bus.busy_vec, 64'd1 << 3);
    step(); bus.alu_valid = 1'b0;
    smp();  chk("raw_hazard_wr", bus.hazard, 1);
            chk("raw_ready_wr", bus.issue_ready, 0);
    step();
    smp();  chk("raw_hazard_done", bus.hazard, 0);
            chk("raw_ready_done", bus.issue_ready, 1);
    step(); issue(1'b0, 5'd0, 1'b0, 5'd0, 5'd0);

    // write to a non-busy reg, same-edge set/clear, then WAW stall
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd6; bus.alu_data = 32'h66;
    push(5'd6, 32'h66);
    smp();  chk("nb_alu_ready", bus.alu_ready, 1);
    step(); bus.alu_valid = 1'b0; issue(1'b1, 5'd6, 1'b1, 5'd0, 5'd0);
    smp();  chk("sc_issue_ready", bus.issue_ready, 1);
    step(); issue(1'b1, 5'd6, 1'b1, 5'd1, 5'd2);
    smp();  chk("sc_set_wins", bus.busy_vec, 64'd1 << 6);
            chk("waw_hazard", bus.hazard, 1);
            chk("waw_ready", bus.issue_ready, 0);
    step(); issue(1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd6; bus.alu_data = 32'h67;
    push(5'd6, 32'h67);
    smp();  chk("waw_alu_ready", bus.alu_ready, 1);
    step(); bus.alu_valid = 1'b0;
    step();
    smp();  chk("waw_busy_clr", bus.busy_vec, 0);

    // x0 handling
    step(); issue(1'b1, 5'd0, 1'b1, 5'd0, 5'd0);
    smp();  chk("x0_issue_ready", bus.issue_ready, 1);
    step(); issue(1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd0; bus.mem_data = 32'h55;
    smp();  chk("x0_mem_ready", bus.mem_ready, 1);
            chk("x0_busy", bus.busy_vec, 0);
    step(); bus.mem_valid = 1'b0;
    smp();  chk("x0_reg_write", bus.reg_write, 0);
            chk("x0_busy_after", bus.busy_vec, 0);

    // conflict from reset: round-robin, load wins first
    step(); rst_n = 1'b0;
    step();
    step(); rst_n = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'h11;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd9; bus.mem_data = 32'h22;
    push(5'd9, 32'h22); push(5'd4, 32'h11); push(5'd10, 32'h33);
    smp();  chk("cf_mem_first", bus.mem_ready, 1);
            chk("cf_alu_wait", bus.alu_ready, 0);
    step(); bus.mem_rd = 5'd10; bus.mem_data = 32'h33;
    smp();  chk("cf_alu_second", bus.alu_ready, 1);
            chk("cf_mem_wait", bus.mem_ready, 0);
            chk("cf_wr1", bus.reg_write, 1);
    step(); bus.alu_valid = 1'b0;
    smp();  chk("cf_mem_third", bus.mem_ready, 1);
            chk("cf_wr2", bus.reg_write, 1);
    step(); bus.mem_valid = 1'b0;
    smp();  chk("cf_wr3", bus.reg_write, 1);
    step();
    smp();  chk("cf_idle", bus.reg_write, 0);

    // reset on the grant edge drops the write
    step(); issue(1'b1, 5'd12, 1'b1, 5'd0, 5'd0);
    smp();  chk("rmw_issue_ready", bus.issue_ready, 1);
    step(); issue(1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd12; bus.alu_data = 32'h1212;
    rst_n = 1'b0;
    smp();  chk("rmw_alu_ready", bus.alu_ready, 1);
            chk("rmw_busy12", bus.busy_vec, 64'd1 << 12);
    step(); bus.alu_valid = 1'b0; rst_n = 1'b1;
    smp();  chk("rmw_reg_write", bus.reg_write, 0);
            chk("rmw_busy", bus.busy_vec, 0);

    step();
    smp();  chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
